// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Receives a byte stream (16-bit LE word count, then LE 32-bit words) and
// writes the words sequentially from word address 0. The core is held in
// reset until the image has been written.
// Build option: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte (XOR of every earlier byte). A mismatch ends in error.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset_hold,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] S_HDR0   = 3'd0;
    localparam logic [2:0] S_HDR1   = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM   = 3'd3;
`endif
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    // State entered once the payload (or an empty header) has been consumed.
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_POST = S_CSUM;
`else
    localparam logic [2:0] S_POST = S_SETTLE;
`endif

    // 17-bit capacity so that a count equal to the full depth is legal.
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    logic [2:0]        state_reg, state_next;
    logic [7:0]        cnt_lo_reg, cnt_lo_next;
    logic [16:0]       rem_reg, rem_next;
    logic [1:0]        bcnt_reg, bcnt_next;
    logic [23:0]       asm_reg, asm_next;
    logic [ADDR_W-1:0] widx_reg, widx_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic              ready_reg, ready_next;
    logic              done_reg, done_next;
    logic              error_reg, error_next;
    logic              hold_reg, hold_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        xor_reg, xor_next;
`endif

    logic        accept;
    logic [16:0] hdr_count;

    // A byte moves only while the registered ready is high.
    assign accept    = in_valid & ready_reg;
    assign hdr_count = {1'b0, in_data, cnt_lo_reg};

    // Next-state logic for the stream parser, word assembly and outputs.
    always_comb begin
        state_next  = state_reg;
        cnt_lo_next = cnt_lo_reg;
        rem_next    = rem_reg;
        bcnt_next   = bcnt_reg;
        asm_next    = asm_reg;
        widx_next   = widx_reg;
        we_next     = 1'b0;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_next    = accept ? (xor_reg ^ in_data) : xor_reg;
`endif
        case (state_reg)
            S_HDR0: begin
                if (accept) begin
                    cnt_lo_next = in_data;
                    state_next  = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    if (hdr_count > DEPTH) begin
                        state_next = S_ERROR;
                    end else if (hdr_count == 17'd0) begin
                        state_next = S_POST;
                    end else begin
                        rem_next   = hdr_count;
                        bcnt_next  = 2'd0;
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    // Bytes enter at the top so the first byte ends up lowest.
                    asm_next  = {in_data, asm_reg[23:8]};
                    bcnt_next = bcnt_reg + 2'd1;
                    if (bcnt_reg == 2'd3) begin
                        we_next    = 1'b1;
                        wdata_next = {in_data, asm_reg};
                        addr_next  = widx_reg;
                        widx_next  = widx_reg + 1'b1;
                        rem_next   = rem_reg - 17'd1;
                        if (rem_reg == 17'd1) begin
                            state_next = S_POST;
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_next = (in_data == xor_reg) ? S_SETTLE : S_ERROR;
                end
            end
`endif
            // One quiet cycle so the last write lands before the core starts.
            S_SETTLE: state_next = S_DONE;
            S_DONE:   state_next = S_DONE;
            S_ERROR:  state_next = S_ERROR;
            default:  state_next = S_ERROR;
        endcase

        ready_next = (state_next == S_HDR0) || (state_next == S_HDR1) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                     (state_next == S_CSUM) ||
`endif
                     (state_next == S_DATA);
        done_next  = (state_next == S_DONE);
        error_next = (state_next == S_ERROR);
        hold_next  = (state_next != S_DONE);
    end

    // State and output registers; reset wins over any concurrent byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= S_HDR0;
            cnt_lo_reg <= 8'd0;
            rem_reg    <= 17'd0;
            bcnt_reg   <= 2'd0;
            asm_reg    <= 24'd0;
            widx_reg   <= '0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= 32'd0;
            ready_reg  <= 1'b0;
            done_reg   <= 1'b0;
            error_reg  <= 1'b0;
            hold_reg   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_reg    <= 8'd0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_lo_reg <= cnt_lo_next;
            rem_reg    <= rem_next;
            bcnt_reg   <= bcnt_next;
            asm_reg    <= asm_next;
            widx_reg   <= widx_next;
            we_reg     <= we_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            ready_reg  <= ready_next;
            done_reg   <= done_next;
            error_reg  <= error_next;
            hold_reg   <= hold_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_reg    <= xor_next;
`endif
        end
    end

    assign in_ready       = ready_reg;
    assign imem_we        = we_reg;
    assign imem_addr      = addr_reg;
    assign imem_wdata     = wdata_reg;
    assign cpu_reset_hold = hold_reg;
    assign done           = done_reg;
    assign error          = error_reg;

endmodule
